hand_sign_accumulator: RTL and testbench

HAND_SIGN_ACCUMULATOR -- requirements
Module: hand_sign_accumulator

---
 rtl/hand_sign_accumulator.sv | 152 +++++++++++++++
 tb/tb_hand_sign_accumulator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hand_sign_accumulator.sv
// hand_sign_accumulator
//   Decodes a W-finger hand sign into a count, debounces it (a value must be
//   seen STABLE consecutive cycles to commit, and commits only once per hold),
//   and accumulates committed valid counts into a saturating sum.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset of all state
//   clear    in   synchronous clear of sum / sum_sat only
//   hs       in   [W-1:0]     hand sign, bit 0 = first finger
//   n        out  [NW-1:0]    last committed valid count
//   n_valid  out              one-cycle pulse per valid commit
//   err      out              one-cycle pulse per invalid-pattern commit
//   sum      out  [SUM_W-1:0] saturating sum of committed valid counts
//   sum_sat  out              sticky: an addition saturated since last clear
//
// There is no handshake: hs is sampled every cycle, and n/n_valid/err/sum are
// registered so that a commit becomes visible in the cycle after the edge
// that sampled its STABLE-th identical decode.
module hand_sign_accumulator #(
  parameter int W      = 5,
  parameter int STABLE = 4,
  parameter int SUM_W  = 8,
  localparam int NW    = $clog2(2*W+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [W-1:0]     hs,
  output logic [NW-1:0]    n,
  output logic             n_valid,
  output logic             err,
  output logic [SUM_W-1:0] sum,
  output logic             sum_sat
);

  localparam logic [7:0]       CNT_LAST = 8'(STABLE - 1);
  localparam int               AW       = ((SUM_W > NW) ? SUM_W : NW) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX  = '1;

  typedef enum logic [0:0] {TRACK = 1'b0, HELD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [NW-1:0]    cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NW-1:0]    n_q, n_d;
  logic             n_valid_q, n_valid_d;
  logic             err_q, err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             sum_sat_q, sum_sat_d;

  logic [NW-1:0]    decode;
  logic             commit;
  logic [AW-1:0]    sum_ext;

  // Decode: k low fingers -> k, (W-j) high fingers -> W+j, none -> 2W,
  // anything else -> 0 (invalid).
  always_comb begin
    decode = '0;
    if (hs == '0) decode = NW'(2*W);
    for (int k = 1; k <= W; k++) begin
      if (hs == W'((1 << k) - 1)) decode = NW'(k);
    end
    for (int j = 1; j < W; j++) begin
      if (hs == W'(~((1 << j) - 1))) decode = NW'(W + j);
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HELD;
      cand_q    <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      n_valid_q <= 1'b0;
      err_q     <= 1'b0;
      sum_q     <= '0;
      sum_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      n_valid_q <= n_valid_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      sum_sat_q <= sum_sat_d;
    end
  end

  // Next-state: any change of decode restarts the run with this sample as
  // its first; HELD absorbs further identical samples so a hold commits once.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    case (state_q)
      TRACK: begin
        if (decode != cand_q) begin
          cand_d = decode;
          cnt_d  = 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (decode != cand_q) begin
          state_d = TRACK;
          cand_d  = decode;
          cnt_d   = 8'd1;
        end
      end
      default: state_d = HELD;
    endcase
  end

  // Outputs: clear zeroes the accumulator before any same-cycle addition.
  always_comb begin
    commit    = (state_q == TRACK) && (decode == cand_q) && (cnt_q == CNT_LAST);
    n_d       = n_q;
    n_valid_d = 1'b0;
    err_d     = 1'b0;
    sum_d     = clear ? '0 : sum_q;
    sum_sat_d = clear ? 1'b0 : sum_sat_q;
    sum_ext   = '0;
    if (commit) begin
      if (decode == '0) begin
        err_d = 1'b1;
      end else begin
        n_d       = decode;
        n_valid_d = 1'b1;
        sum_ext   = AW'(sum_d) + AW'(decode);
        if (sum_ext > AW'(SUM_MAX)) begin
          sum_d     = SUM_MAX;
          sum_sat_d = 1'b1;
        end else begin
          sum_d = sum_ext[SUM_W-1:0];
        end
      end
    end
  end

  assign n       = n_q;
  assign n_valid = n_valid_q;
  assign err     = err_q;
  assign sum     = sum_q;
  assign sum_sat = sum_sat_q;

endmodule

// File: tb/tb_hand_sign_accumulator.sv
module tb_hand_sign_accumulator;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [4:0] hs;
  logic [3:0] n;
  logic       n_valid;
  logic       err;
  logic [7:0] sum;
  logic       sum_sat;

  always #5 clk = ~clk;

  hand_sign_accumulator #(.W(5), .STABLE(4), .SUM_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .hs      (hs),
    .n       (n),
    .n_valid (n_valid),
    .err     (err),
    .sum     (sum),
    .sum_sat (sum_sat)
  );

  int checks   = 0;
  int failures = 0;
  int nv_seen  = 0;
  int err_seen = 0;
  int nv_mark;
  int err_mark;

  // ---------------- driver tasks ----------------
  // Apply one sample: drive hs, take one edge, then look at the outputs
  // 1 time unit after the edge and tally any pulses.
  task automatic step(input logic [4:0] v);
    hs = v;
    @(posedge clk);
    #1;
    if (n_valid === 1'b1) nv_seen++;
    if (err === 1'b1) err_seen++;
  endtask

  task automatic hold(input logic [4:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) step(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    clear = 1'b0;
    hs    = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_n",       32'(n),       32'd0);
    check("rst_n_valid", 32'(n_valid), 32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_sum",     32'(sum),     32'd0);
    check("rst_sum_sat", 32'(sum_sat), 32'd0);
    reset = 1'b0;

    // 00011 -> 2: pulse exactly in the cycle after the 4th sample.
    hold(5'b00011, 3);
    check("lat_no_early", 32'(n_valid), 32'd0);
    step(5'b00011);
    check("lat_pulse", 32'(n_valid), 32'd1);
    check("c2_n",      32'(n),       32'd2);
    check("c2_sum",    32'(sum),     32'd2);
    step(5'b00011);
    check("c2_pulse_end", 32'(n_valid), 32'd0);

    // 00111 for 3 (no commit), then 01111 for 4 -> single commit of 4.
    nv_mark = nv_seen;
    hold(5'b00111, 3);
    hold(5'b01111, 4);
    check("c4_pulses", 32'(nv_seen - nv_mark), 32'd1);
    check("c4_n",      32'(n),   32'd4);
    check("c4_sum",    32'(sum), 32'd6);

    // 11100 (three high fingers) -> 7, held 20 cycles commits once.
    nv_mark = nv_seen;
    hold(5'b11100, 20);
    check("c7_pulses", 32'(nv_seen - nv_mark), 32'd1);
    check("c7_n",      32'(n),   32'd7);
    check("c7_sum",    32'(sum), 32'd13);

    // Invalid pattern: one err pulse, n and sum untouched.
    nv_mark  = nv_seen;
    err_mark = err_seen;
    hold(5'b10101, 4);
    check("inv_err_now", 32'(err),                 32'd1);
    check("inv_errs",    32'(err_seen - err_mark), 32'd1);
    check("inv_nv",      32'(nv_seen - nv_mark),   32'd0);
    check("inv_n",       32'(n),   32'd7);
    check("inv_sum",     32'(sum), 32'd13);
    step(5'b10101);
    check("inv_err_end", 32'(err), 32'd0);

    // Clear with no commit.
    clear = 1'b1;
    step(5'b10101);
    clear = 1'b0;
    check("clr_sum", 32'(sum), 32'd0);
    check("clr_n",   32'(n),   32'd7);

    // 25 commits of 10, each separated by one 00001 sample (too short to commit).
    nv_mark = nv_seen;
    for (int i = 0; i < 25; i++) begin
      step(5'b00001);
      hold(5'b00000, 4);
    end
    check("acc_pulses",  32'(nv_seen - nv_mark), 32'd25);
    check("acc_sum",     32'(sum),     32'd250);
    check("acc_sat",     32'(sum_sat), 32'd0);
    check("acc_n",       32'(n),       32'd10);
    step(5'b00001);
    hold(5'b00000, 4);
    check("sat_sum", 32'(sum),     32'd255);
    check("sat_flag", 32'(sum_sat), 32'd1);
    hold(5'b00001, 4);
    check("sat_stay_sum",  32'(sum),     32'd255);
    check("sat_stay_flag", 32'(sum_sat), 32'd1);
    check("sat_stay_n",    32'(n),       32'd1);

    clear = 1'b1;
    step(5'b00001);
    clear = 1'b0;
    check("clr2_sum", 32'(sum),     32'd0);
    check("clr2_sat", 32'(sum_sat), 32'd0);

    // Build sum=1, then clear coinciding with a commit of 3 gives 3, not 4.
    hold(5'b00011, 1);
    hold(5'b00001, 4);
    check("pre_sum", 32'(sum), 32'd1);
    hold(5'b00111, 3);
    clear = 1'b1;
    step(5'b00111);
    clear = 1'b0;
    check("clrc_nv",  32'(n_valid), 32'd1);
    check("clrc_n",   32'(n),       32'd3);
    check("clrc_sum", 32'(sum),     32'd3);
    check("clrc_sat", 32'(sum_sat), 32'd0);

    // Reset on what would have been the 4th sample of 11000 (code 8).
    nv_mark = nv_seen;
    hold(5'b11000, 3);
    reset = 1'b1;
    step(5'b11000);
    reset = 1'b0;
    check("rr_nv_pulses", 32'(nv_seen - nv_mark), 32'd0);
    check("rr_n",       32'(n),       32'd0);
    check("rr_n_valid", 32'(n_valid), 32'd0);
    check("rr_err",     32'(err),     32'd0);
    check("rr_sum",     32'(sum),     32'd0);
    check("rr_sum_sat", 32'(sum_sat), 32'd0);

    // Invalid pattern present straight after reset produces no err.
    err_mark = err_seen;
    hold(5'b10101, 6);
    check("rr_inv_errs", 32'(err_seen - err_mark), 32'd0);

    nv_mark = nv_seen;
    hold(5'b11111, 4);
    check("c5_pulses", 32'(nv_seen - nv_mark), 32'd1);
    check("c5_n",      32'(n),   32'd5);
    check("c5_sum",    32'(sum), 32'd5);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
